// File: rtl/mem_pkg.sv
// Shared definitions for the memory-access stage: func3 encodings and FSM states.
package mem_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } mem_state_t;

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: store byte enables/data replication, access
// legality, and load extraction/extension from the returned bus word.
module lsu_align
  import mem_pkg::*;
(
  input  logic [2:0]  func3,
  input  logic [1:0]  lane,
  input  logic [31:0] st_data,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic        bad,
  input  logic [2:0]  ld_func3,
  input  logic [1:0]  ld_lane,
  input  logic [31:0] rdata,
  output logic [31:0] ld_data
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  // Size comes from func3[1:0]; the sign bit func3[2] does not change lanes.
  always_comb begin
    be    = 4'b0000;
    wdata = 32'h0;
    bad   = 1'b0;
    case (func3)
      F3_LB, F3_LBU: begin
        be    = 4'b0001 << lane;
        wdata = {4{st_data[7:0]}};
      end
      F3_LH, F3_LHU: begin
        be    = 4'b0011 << {lane[1], 1'b0};
        wdata = {2{st_data[15:0]}};
        bad   = lane[0];
      end
      F3_LW: begin
        be    = 4'b1111;
        wdata = st_data;
        bad   = |lane;
      end
      default: bad = 1'b1;
    endcase
  end

  always_comb begin
    ld_byte = rdata[{ld_lane, 3'b000} +: 8];
    ld_half = rdata[{ld_lane[1], 4'b0000} +: 16];
    case (ld_func3)
      F3_LB:   ld_data = {{24{ld_byte[7]}}, ld_byte};
      F3_LBU:  ld_data = {24'h0, ld_byte};
      F3_LH:   ld_data = {{16{ld_half[15]}}, ld_half};
      F3_LHU:  ld_data = {16'h0, ld_half};
      default: ld_data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: issues loads/stores on a req/ack data bus,
// stalls upstream while an access is outstanding and registers write-back.
module mem_stage
  import mem_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid,
  input  logic        ex_mem_r,
  input  logic        ex_mem_w,
  input  logic        ex_reg_w,
  input  logic [2:0]  ex_func3,
  input  logic [31:0] ex_alu_res,
  input  logic [31:0] ex_rs2_data,
  input  logic [4:0]  ex_rd_addr,
  output logic        stall,
  output logic        dm_req,
  output logic        dm_we,
  output logic [31:0] dm_addr,
  output logic [3:0]  dm_be,
  output logic [31:0] dm_wdata,
  input  logic        dm_ack,
  input  logic [31:0] dm_rdata,
  output logic        wb_valid,
  output logic        wb_reg_w,
  output logic [4:0]  wb_rd_addr,
  output logic [31:0] wb_data,
  output logic        misalign_err,
  output logic [31:0] mem_fwd_data,
  output logic        mem_fwd_we
);

  mem_state_t  state;
  logic [2:0]  cap_func3;
  logic [1:0]  cap_lane;
  logic        cap_we;
  logic        cap_reg_w;
  logic [4:0]  cap_rd;
  logic [31:0] cap_res;

  logic        completing;
  logic        accept;
  logic        is_mem;
  logic [3:0]  al_be;
  logic [31:0] al_wdata;
  logic        al_bad;
  logic [31:0] ld_data;

  assign completing   = (state == BUSY) & dm_ack;
  assign stall        = (state == BUSY) & ~dm_ack;
  assign accept       = ex_valid & ~stall;
  assign is_mem       = ex_mem_r | ex_mem_w;
  assign mem_fwd_data = wb_data;
  assign mem_fwd_we   = wb_valid & wb_reg_w;

  lsu_align u_align (
    .func3    (ex_func3),
    .lane     (ex_alu_res[1:0]),
    .st_data  (ex_rs2_data),
    .be       (al_be),
    .wdata    (al_wdata),
    .bad      (al_bad),
    .ld_func3 (cap_func3),
    .ld_lane  (cap_lane),
    .rdata    (dm_rdata),
    .ld_data  (ld_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      dm_req       <= 1'b0;
      dm_we        <= 1'b0;
      dm_addr      <= 32'h0;
      dm_be        <= 4'h0;
      dm_wdata     <= 32'h0;
      wb_valid     <= 1'b0;
      wb_reg_w     <= 1'b0;
      wb_rd_addr   <= 5'h0;
      wb_data      <= 32'h0;
      misalign_err <= 1'b0;
      cap_func3    <= 3'h0;
      cap_lane     <= 2'h0;
      cap_we       <= 1'b0;
      cap_reg_w    <= 1'b0;
      cap_rd       <= 5'h0;
      cap_res      <= 32'h0;
    end else begin
      wb_valid     <= 1'b0;
      misalign_err <= 1'b0;
      if (completing) begin
        state      <= IDLE;
        dm_req     <= 1'b0;
        wb_valid   <= 1'b1;
        wb_reg_w   <= ~cap_we & cap_reg_w;
        wb_rd_addr <= cap_rd;
        wb_data    <= cap_we ? cap_res : ld_data;
      end
      if (accept) begin
        if (is_mem && !al_bad) begin
          state     <= BUSY;
          dm_req    <= 1'b1;
          dm_we     <= ex_mem_w;
          dm_addr   <= {ex_alu_res[31:2], 2'b00};
          dm_be     <= al_be;
          dm_wdata  <= ex_mem_w ? al_wdata : 32'h0;
          cap_func3 <= ex_func3;
          cap_lane  <= ex_alu_res[1:0];
          cap_we    <= ex_mem_w;
          cap_reg_w <= ex_reg_w;
          cap_rd    <= ex_rd_addr;
          cap_res   <= ex_alu_res;
        end else if (!completing) begin
          // The write-back slot of an ack cycle belongs to the completing
          // access; execute only issues memory ops back-to-back with an ack.
          wb_valid     <= 1'b1;
          wb_reg_w     <= ~is_mem & ex_reg_w;
          wb_rd_addr   <= ex_rd_addr;
          wb_data      <= ex_alu_res;
          misalign_err <= is_mem;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed scenarios with literal
// expectations, then randomized traffic against a transaction-level model.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid, ex_mem_r, ex_mem_w, ex_reg_w;
  logic [2:0]  ex_func3;
  logic [31:0] ex_alu_res, ex_rs2_data;
  logic [4:0]  ex_rd_addr;
  logic        stall, dm_req, dm_we, dm_ack;
  logic [31:0] dm_addr, dm_wdata, dm_rdata;
  logic [3:0]  dm_be;
  logic        wb_valid, wb_reg_w, misalign_err, mem_fwd_we;
  logic [4:0]  wb_rd_addr;
  logic [31:0] wb_data, mem_fwd_data;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_stage dut (
    .clk(clk), .rst(rst),
    .ex_valid(ex_valid), .ex_mem_r(ex_mem_r), .ex_mem_w(ex_mem_w),
    .ex_reg_w(ex_reg_w), .ex_func3(ex_func3), .ex_alu_res(ex_alu_res),
    .ex_rs2_data(ex_rs2_data), .ex_rd_addr(ex_rd_addr),
    .stall(stall), .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr),
    .dm_be(dm_be), .dm_wdata(dm_wdata), .dm_ack(dm_ack), .dm_rdata(dm_rdata),
    .wb_valid(wb_valid), .wb_reg_w(wb_reg_w), .wb_rd_addr(wb_rd_addr),
    .wb_data(wb_data), .misalign_err(misalign_err),
    .mem_fwd_data(mem_fwd_data), .mem_fwd_we(mem_fwd_we)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int nbytes(input logic [2:0] f3);
    case (f3[1:0])
      2'd0:    return 1;
      2'd1:    return 2;
      default: return 4;
    endcase
  endfunction

  function automatic bit legal(input logic [2:0] f3, input logic [31:0] addr);
    if (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7) return 1'b0;
    return (addr % nbytes(f3)) == 0;
  endfunction

  function automatic logic [3:0] model_be(input logic [2:0] f3, input logic [31:0] addr);
    int n = nbytes(f3);
    int v = ((1 << n) - 1) << (addr % 4);
    return v[3:0];
  endfunction

  function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] d);
    case (nbytes(f3))
      1:       return 32'h01010101 * (d & 32'hFF);
      2:       return 32'h00010001 * (d & 32'hFFFF);
      default: return d;
    endcase
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] addr,
                                             input logic [31:0] rdata);
    int n = nbytes(f3);
    logic [31:0] mask, v;
    if (n == 4) return rdata;
    mask = (n == 1) ? 32'hFF : 32'hFFFF;
    v = (rdata >> ((addr % 4) * 8)) & mask;
    if (!f3[2] && v[8*n-1]) v = v | ~mask;
    return v;
  endfunction

  // Model state: outstanding access and expected registered outputs.
  bit          busy = 1'b0;
  logic [31:0] p_addr;
  logic [2:0]  p_f3;
  bit          p_store, p_regw;
  logic [4:0]  p_rd;
  bit          e_wbv = 1'b0, e_err = 1'b0, e_req = 1'b0, e_we = 1'b0;
  logic [31:0] e_addr = '0, e_wdata = '0;
  logic [3:0]  e_be = '0;
  logic [37:0] exp_q[$];

  always @(negedge clk) begin
    logic [37:0] b;
    bit nwbv, nerr, completing, acc;
    chk("stall", stall, busy & ~dm_ack);
    chk("wb_valid", wb_valid, e_wbv);
    chk("misalign_err", misalign_err, e_err);
    chk("dm_req", dm_req, e_req);
    if (e_wbv && exp_q.size() > 0) begin
      b = exp_q.pop_front();
      chk("wb_reg_w", wb_reg_w, b[37]);
      chk("mem_fwd_we", mem_fwd_we, b[37]);
      if (b[37]) begin
        chk("wb_rd_addr", wb_rd_addr, b[36:32]);
        chk("wb_data", wb_data, b[31:0]);
        chk("mem_fwd_data", mem_fwd_data, b[31:0]);
      end
    end else begin
      chk("mem_fwd_we_idle", mem_fwd_we, 1'b0);
    end
    if (e_req) begin
      chk("dm_we", dm_we, e_we);
      chk("dm_addr", dm_addr, e_addr);
      chk("dm_be", dm_be, e_be);
      if (e_we) chk("dm_wdata", dm_wdata, e_wdata);
    end

    nwbv = 1'b0;
    nerr = 1'b0;
    if (rst) begin
      busy = 1'b0; e_req = 1'b0; e_we = 1'b0;
      e_addr = '0; e_be = '0; e_wdata = '0;
      exp_q.delete();
    end else begin
      completing = busy && dm_ack;
      acc = ex_valid && !(busy && !dm_ack);
      if (completing) begin
        nwbv = 1'b1;
        if (p_store) exp_q.push_back({1'b0, p_rd, p_addr});
        else exp_q.push_back({p_regw, p_rd, model_load(p_f3, p_addr, dm_rdata)});
        busy = 1'b0;
        e_req = 1'b0;
      end
      if (acc) begin
        if ((ex_mem_r || ex_mem_w) && legal(ex_func3, ex_alu_res)) begin
          busy = 1'b1; e_req = 1'b1; e_we = ex_mem_w;
          e_addr = ex_alu_res & 32'hFFFFFFFC;
          e_be = model_be(ex_func3, ex_alu_res);
          e_wdata = model_wdata(ex_func3, ex_rs2_data);
          p_addr = ex_alu_res; p_f3 = ex_func3; p_store = ex_mem_w;
          p_regw = ex_reg_w; p_rd = ex_rd_addr;
        end else if (!completing) begin
          nwbv = 1'b1;
          nerr = ex_mem_r || ex_mem_w;
          exp_q.push_back({ex_reg_w && !nerr, ex_rd_addr, ex_alu_res});
        end
      end
    end
    e_wbv = nwbv;
    e_err = nerr;
  end

  // ---------------- driver ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_ex();
    ex_valid = 0; ex_mem_r = 0; ex_mem_w = 0; ex_reg_w = 0;
  endtask

  task automatic drive_mem(input bit w, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] d, input logic [4:0] rd);
    ex_valid = 1; ex_mem_r = !w; ex_mem_w = w; ex_reg_w = !w;
    ex_func3 = f3; ex_alu_res = addr; ex_rs2_data = d; ex_rd_addr = rd;
  endtask

  initial begin
    logic [31:0] first_word;
    rst = 1; dm_ack = 0; dm_rdata = 0;
    ex_func3 = 0; ex_alu_res = 0; ex_rs2_data = 0; ex_rd_addr = 0;
    clear_ex();
    tick(); tick();
    chk("reset_dm_req", dm_req, 0);
    chk("reset_wb_valid", wb_valid, 0);
    chk("reset_wb_data", wb_data, 0);
    chk("reset_dm_addr", dm_addr, 0);
    rst = 0;
    tick();

    // ALU result forwarded straight to write-back
    ex_valid = 1; ex_reg_w = 1; ex_alu_res = 32'h1234; ex_rd_addr = 5;
    tick();
    clear_ex();
    chk("alu_wb_valid", wb_valid, 1);
    chk("alu_wb_data", wb_data, 32'h1234);
    chk("alu_fwd_we", mem_fwd_we, 1);
    chk("alu_stall", stall, 0);

    // LB at 0x103, ack after 3 stalled cycles
    drive_mem(0, 3'b000, 32'h103, 0, 7);
    tick();
    clear_ex();
    chk("lb_dm_addr", dm_addr, 32'h100);
    chk("lb_dm_be", dm_be, 4'b1000);
    for (int i = 0; i < 3; i++) begin
      chk("lb_stall", stall, 1);
      tick();
    end
    dm_ack = 1; dm_rdata = 32'h80AABBCC;
    #1 chk("lb_stall_ack", stall, 0);
    tick();
    dm_ack = 0;
    chk("lb_wb_valid", wb_valid, 1);
    chk("lb_wb_data", wb_data, 32'hFFFFFF80);

    // LHU at 0x102, ack in the first request cycle
    drive_mem(0, 3'b101, 32'h102, 0, 8);
    tick();
    clear_ex();
    dm_ack = 1;
    tick();
    dm_ack = 0;
    chk("lhu_wb_data", wb_data, 32'h000080AA);

    // SB at 0x101
    drive_mem(1, 3'b000, 32'h101, 32'h000000A5, 0);
    tick();
    clear_ex();
    chk("sb_dm_we", dm_we, 1);
    chk("sb_dm_be", dm_be, 4'b0010);
    chk("sb_dm_wdata", dm_wdata, 32'hA5A5A5A5);
    dm_ack = 1;
    tick();
    dm_ack = 0;
    chk("sb_wb_valid", wb_valid, 1);
    chk("sb_wb_reg_w", wb_reg_w, 0);

    // Misaligned SW is dropped
    drive_mem(1, 3'b010, 32'h102, 32'hDEADBEEF, 0);
    tick();
    clear_ex();
    chk("sw_bad_req", dm_req, 0);
    chk("sw_bad_err", misalign_err, 1);
    chk("sw_bad_wbv", wb_valid, 1);
    chk("sw_bad_regw", wb_reg_w, 0);
    tick();
    chk("sw_bad_err_pulse", misalign_err, 0);

    // Back-to-back LW accepted in the ack cycle, then reset while busy
    drive_mem(0, 3'b010, 32'h200, 0, 9);
    tick();
    first_word = 32'h13572468;
    dm_ack = 1; dm_rdata = first_word;
    drive_mem(0, 3'b010, 32'h204, 0, 10);
    #1 chk("b2b_stall", stall, 0);
    tick();
    clear_ex();
    dm_ack = 0;
    chk("b2b_req", dm_req, 1);
    chk("b2b_addr", dm_addr, 32'h204);
    chk("b2b_wb_data", wb_data, first_word);
    rst = 1;
    tick();
    rst = 0;
    chk("rst_busy_req", dm_req, 0);
    dm_ack = 1;
    tick();
    dm_ack = 0;
    chk("late_ack_wbv", wb_valid, 0);

    // Randomized traffic
    for (int cyc = 0; cyc < 3000; cyc++) begin
      int kind;
      rst = ($urandom_range(0, 199) == 0);
      dm_rdata = $urandom;
      dm_ack = busy ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 3) == 0);
      ex_valid = $urandom_range(0, 1);
      kind = $urandom_range(0, 3);
      ex_func3 = $urandom_range(0, 7);
      ex_alu_res = $urandom;
      ex_rs2_data = $urandom;
      ex_rd_addr = $urandom_range(0, 31);
      ex_reg_w = $urandom_range(0, 1);
      if (busy && dm_ack && ex_valid) begin
        kind = $urandom_range(1, 3);
        ex_func3 = $urandom_range(0, 2);
        ex_alu_res[1:0] = 2'b00;
      end
      ex_mem_r = (kind == 1) || (kind == 3);
      ex_mem_w = (kind == 2) || (kind == 3);
      tick();
    end
    rst = 0; dm_ack = 0;
    clear_ex();
    tick(); tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
